// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and constants for the multi-source interrupt controller
package int_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ASK  = 1'b1
    } state_t;

    localparam logic CFG_SEL_MASK = 1'b0;
    localparam logic CFG_SEL_CLR  = 1'b1;

endpackage

// File: rtl/int_ctrl_nsrc_if.sv
// rtl/int_ctrl_nsrc_if.sv - vectored request/acknowledge handshake between controller and core
interface int_ctrl_nsrc_if #(
    parameter int NUM_W = 8
) ();
    logic             int_ask;
    logic [NUM_W-1:0] int_num;
    logic             int_ack;
    logic             int_eoi;

    modport master (
        output int_ask,
        output int_num,
        input  int_ack,
        input  int_eoi
    );

    modport slave (
        input  int_ask,
        input  int_num,
        output int_ack,
        output int_eoi
    );
endinterface

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - lowest-set-bit priority encoder with valid flag
module prio_enc_lsb #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/int_ctrl_nsrc.sv
// rtl/int_ctrl_nsrc.sv - edge-latched, masked, fixed-priority nested interrupt controller
module int_ctrl_nsrc
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC  = 16,
    parameter int NUM_W    = 8,
    parameter int VEC_BASE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic               gie,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [NUM_SRC-1:0] cfg_wdata,
    int_ctrl_nsrc_if.master    core,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] isr_o,
    output logic [NUM_SRC-1:0] enable_o
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] isr_q;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] armed;
    logic [NUM_SRC-1:0] req_edge;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] ack_mask;
    logic [NUM_SRC-1:0] eoi_mask;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   cur_idx_q;
    logic [IDX_W-1:0]   cand_idx;
    logic [IDX_W-1:0]   isr_idx;
    logic               cand_vld;
    logic               isr_vld;
    logic               cand_ok;
    logic               take;
    logic               ack_hit;
    logic [NUM_W-1:0]   int_num_q;

    assign armed = pending_q & enable_q;

    prio_enc_lsb #(.N(NUM_SRC), .W(IDX_W)) u_cand_enc (
        .vec   (armed),
        .idx   (cand_idx),
        .valid (cand_vld)
    );

    prio_enc_lsb #(.N(NUM_SRC), .W(IDX_W)) u_isr_enc (
        .vec   (isr_q),
        .idx   (isr_idx),
        .valid (isr_vld)
    );

    // Only a strictly higher-priority source may preempt the innermost handler.
    assign cand_ok = cand_vld && (!isr_vld || (cand_idx < isr_idx));

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        ack_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (gie && cand_ok) begin
                    take    = 1'b1;
                    state_d = ASK;
                end
            end
            ASK: begin
                if (core.int_ack) begin
                    ack_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_edge = src_req & ~src_q;
    assign clr_mask = (cfg_we && (cfg_sel == CFG_SEL_CLR)) ? cfg_wdata : '0;
    assign ack_mask = ack_hit ? (NUM_SRC'(1) << cur_idx_q) : '0;
    assign eoi_mask = (core.int_eoi && isr_vld) ? (NUM_SRC'(1) << isr_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            pending_q <= '0;
            isr_q     <= '0;
            enable_q  <= '0;
            state_q   <= IDLE;
            cur_idx_q <= '0;
            int_num_q <= '0;
        end else begin
            src_q     <= src_req;
            // A fresh edge outranks a clear arriving in the same cycle.
            pending_q <= (pending_q & ~clr_mask & ~ack_mask) | req_edge;
            isr_q     <= (isr_q & ~eoi_mask) | ack_mask;
            if (cfg_we && (cfg_sel == CFG_SEL_MASK)) enable_q <= cfg_wdata;
            state_q   <= state_d;
            if (take) begin
                cur_idx_q <= cand_idx;
                int_num_q <= NUM_W'(VEC_BASE) + NUM_W'(cand_idx);
            end
        end
    end

    assign core.int_ask = (state_q == ASK);
    assign core.int_num = int_num_q;
    assign pending_o    = pending_q;
    assign isr_o        = isr_q;
    assign enable_o     = enable_q;

endmodule

// File: tb/tb_int_ctrl_nsrc.sv
// tb/tb_int_ctrl_nsrc.sv - table, directed and randomized checks of int_ctrl_nsrc against a reference model
module tb_int_ctrl_nsrc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] src_req = '0;
    logic        gie = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [15:0] cfg_wdata = '0;
    logic        ack = 1'b0;
    logic        eoi = 1'b0;

    logic [15:0] pend0, isr0, en0, pend1, isr1, en1;

    int n_vec = 0;
    int n_bad = 0;

    int_ctrl_nsrc_if #(.NUM_W(8)) ifc0 ();
    int_ctrl_nsrc_if #(.NUM_W(8)) ifc1 ();

    assign ifc0.int_ack = ack;
    assign ifc0.int_eoi = eoi;
    assign ifc1.int_ack = ack;
    assign ifc1.int_eoi = eoi;

    int_ctrl_nsrc #(.NUM_SRC(16), .NUM_W(8), .VEC_BASE(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_req   (src_req),
        .gie       (gie),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .core      (ifc0.master),
        .pending_o (pend0),
        .isr_o     (isr0),
        .enable_o  (en0)
    );

    int_ctrl_nsrc #(.NUM_SRC(16), .NUM_W(8), .VEC_BASE('hF8)) dut_wrap (
        .clk       (clk),
        .rst       (rst),
        .src_req   (src_req),
        .gie       (gie),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .core      (ifc1.master),
        .pending_o (pend1),
        .isr_o     (isr1),
        .enable_o  (en1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic        gie;
        logic        we;
        logic        sel;
        logic [15:0] wd;
        logic        ack;
        logic        eoi;
        logic        ask;
        logic [7:0]  num;
        logic [15:0] pend;
        logic [15:0] isr;
        logic [15:0] en;
    } vec_t;

    vec_t tbl[$];

    // Reference model: plain bit arrays updated from the behavioural rules.
    bit [15:0] m_srcq, m_pend, m_isr, m_en;
    bit        m_ask;
    int        m_idx;

    task automatic model_step();
        int        isr_low;
        int        cand;
        bit        hit;
        bit [15:0] np;
        if (rst) begin
            m_srcq = '0; m_pend = '0; m_isr = '0; m_en = '0; m_ask = 1'b0; m_idx = 0;
            return;
        end
        isr_low = -1;
        for (int i = 15; i >= 0; i--) if (m_isr[i]) isr_low = i;
        cand = -1;
        for (int i = 15; i >= 0; i--) if (m_pend[i] && m_en[i]) cand = i;
        hit = m_ask && ack;
        for (int i = 0; i < 16; i++) begin
            np[i] = (src_req[i] && !m_srcq[i]) ||
                    (m_pend[i] && !(cfg_we && cfg_sel && cfg_wdata[i]) && !(hit && i == m_idx));
        end
        if (eoi && isr_low >= 0) m_isr[isr_low] = 1'b0;
        if (hit) begin
            m_isr[m_idx] = 1'b1;
            m_ask = 1'b0;
        end else if (!m_ask && gie && cand >= 0 && (isr_low < 0 || cand < isr_low)) begin
            m_ask = 1'b1;
            m_idx = cand;
        end
        m_pend = np;
        if (cfg_we && !cfg_sel) m_en = cfg_wdata;
        m_srcq = src_req;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic quiet();
        src_req = '0; gie = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_wdata = '0; ack = 1'b0; eoi = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_ask"}, {31'd0, ifc0.int_ask}, {31'd0, m_ask});
        chk({tag, "_ask_wrap"}, {31'd0, ifc1.int_ask}, {31'd0, m_ask});
        if (m_ask) begin
            chk({tag, "_num"}, {24'd0, ifc0.int_num}, {24'd0, 8'(m_idx)});
            chk({tag, "_num_wrap"}, {24'd0, ifc1.int_num}, {24'd0, 8'(m_idx + 'hF8)});
        end
        chk({tag, "_pend"}, {16'd0, pend0}, {16'd0, m_pend});
        chk({tag, "_isr"}, {16'd0, isr0}, {16'd0, m_isr});
        chk({tag, "_en"}, {16'd0, en0}, {16'd0, m_en});
    endtask

    function automatic vec_t mk(logic [15:0] req, logic g, logic we, logic sel, logic [15:0] wd,
                                logic a, logic e, logic ask, logic [7:0] num,
                                logic [15:0] pend, logic [15:0] isr, logic [15:0] en);
        vec_t v;
        v.req = req; v.gie = g; v.we = we; v.sel = sel; v.wd = wd; v.ack = a; v.eoi = e;
        v.ask = ask; v.num = num; v.pend = pend; v.isr = isr; v.en = en;
        return v;
    endfunction

    initial begin
        //                   req   gie we sel wd     ack eoi ask num   pend     isr      en
        // basic interrupt on source 4
        tbl.push_back(mk(16'h0000, 1, 1, 0, 16'h0010, 0, 0, 0, 8'd0,  16'h0000, 16'h0000, 16'h0010));
        tbl.push_back(mk(16'h0010, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0010, 16'h0000, 16'h0010));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 8'd4,  16'h0010, 16'h0000, 16'h0010));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 8'd0,  16'h0000, 16'h0010, 16'h0010));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 8'd0,  16'h0000, 16'h0000, 16'h0010));
        // simultaneous edges on sources 3 and 9
        tbl.push_back(mk(16'h0000, 1, 1, 0, 16'hFFFF, 0, 0, 0, 8'd0,  16'h0000, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0208, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0208, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 8'd3,  16'h0208, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 8'd0,  16'h0200, 16'h0008, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0200, 16'h0008, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 8'd0,  16'h0200, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 8'd9,  16'h0200, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 8'd0,  16'h0000, 16'h0200, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 8'd0,  16'h0000, 16'h0000, 16'hFFFF));
        // nesting: source 5 in service, source 2 preempts
        tbl.push_back(mk(16'h0020, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0020, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 8'd5,  16'h0020, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 8'd0,  16'h0000, 16'h0020, 16'hFFFF));
        tbl.push_back(mk(16'h0004, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0004, 16'h0020, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 8'd2,  16'h0004, 16'h0020, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 8'd0,  16'h0000, 16'h0024, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 8'd0,  16'h0000, 16'h0020, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 8'd0,  16'h0000, 16'h0000, 16'hFFFF));
        // held handshake on source 7 while source 1 fires and gie drops
        tbl.push_back(mk(16'h0080, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0080, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 8'd7,  16'h0080, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0002, 0, 0, 0, 16'h0000, 0, 0, 1, 8'd7,  16'h0082, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 8'd7,  16'h0082, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 8'd0,  16'h0002, 16'h0080, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 8'd1,  16'h0002, 16'h0080, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 8'd0,  16'h0000, 16'h0082, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 8'd0,  16'h0000, 16'h0080, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 8'd0,  16'h0000, 16'h0000, 16'hFFFF));
        // masked source 6 stays pending, unmask presents it
        tbl.push_back(mk(16'h0000, 1, 1, 0, 16'hFFBF, 0, 0, 0, 8'd0,  16'h0000, 16'h0000, 16'hFFBF));
        tbl.push_back(mk(16'h0040, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0040, 16'h0000, 16'hFFBF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0040, 16'h0000, 16'hFFBF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0040, 16'h0000, 16'hFFBF));
        tbl.push_back(mk(16'h0000, 1, 1, 0, 16'hFFFF, 0, 0, 0, 8'd0,  16'h0040, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 8'd6,  16'h0040, 16'h0000, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 8'd0,  16'h0000, 16'h0040, 16'hFFFF));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 8'd0,  16'h0000, 16'h0000, 16'hFFFF));
        // write-1-to-clear, and clear colliding with a new edge
        tbl.push_back(mk(16'h0000, 1, 1, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(16'h0040, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0040, 16'h0000, 16'h0000));
        tbl.push_back(mk(16'h0000, 1, 1, 1, 16'h0040, 0, 0, 0, 8'd0,  16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(16'h0040, 1, 1, 1, 16'h0040, 0, 0, 0, 8'd0,  16'h0040, 16'h0000, 16'h0000));
        tbl.push_back(mk(16'h0000, 1, 1, 1, 16'h0040, 0, 0, 0, 8'd0,  16'h0000, 16'h0000, 16'h0000));
        // source 10: vector wraps to 0x02 on the VEC_BASE=0xF8 instance
        tbl.push_back(mk(16'h0000, 1, 1, 0, 16'h0400, 0, 0, 0, 8'd0,  16'h0000, 16'h0000, 16'h0400));
        tbl.push_back(mk(16'h0400, 1, 0, 0, 16'h0000, 0, 0, 0, 8'd0,  16'h0400, 16'h0000, 16'h0400));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 8'd10, 16'h0400, 16'h0000, 16'h0400));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0, 8'd0,  16'h0000, 16'h0400, 16'h0400));
        tbl.push_back(mk(16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 8'd0,  16'h0000, 16'h0000, 16'h0400));

        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ask", {31'd0, ifc0.int_ask}, 32'd0);
        chk("rst_num", {24'd0, ifc0.int_num}, 32'd0);
        chk("rst_pend", {16'd0, pend0}, 32'd0);
        chk("rst_isr", {16'd0, isr0}, 32'd0);
        chk("rst_en", {16'd0, en0}, 32'd0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            src_req = tbl[k].req; gie = tbl[k].gie; cfg_we = tbl[k].we; cfg_sel = tbl[k].sel;
            cfg_wdata = tbl[k].wd; ack = tbl[k].ack; eoi = tbl[k].eoi;
            tick();
            chk($sformatf("tbl%0d_ask", k), {31'd0, ifc0.int_ask}, {31'd0, tbl[k].ask});
            if (tbl[k].ask) begin
                chk($sformatf("tbl%0d_num", k), {24'd0, ifc0.int_num}, {24'd0, tbl[k].num});
                chk($sformatf("tbl%0d_num_wrap", k), {24'd0, ifc1.int_num},
                    {24'd0, 8'(tbl[k].num + 8'hF8)});
            end
            chk($sformatf("tbl%0d_pend", k), {16'd0, pend0}, {16'd0, tbl[k].pend});
            chk($sformatf("tbl%0d_isr", k), {16'd0, isr0}, {16'd0, tbl[k].isr});
            chk($sformatf("tbl%0d_en", k), {16'd0, en0}, {16'd0, tbl[k].en});
        end
        quiet();

        // randomized traffic against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            src_req   = 16'($urandom & $urandom & $urandom);
            gie       = ($urandom % 8) != 0;
            cfg_we    = ($urandom % 16) == 0;
            cfg_sel   = 1'($urandom % 2);
            cfg_wdata = 16'($urandom);
            ack       = ($urandom % 3) == 0;
            eoi       = ($urandom % 6) == 0;
            tick();
            chk_model("rnd");
        end
        quiet();

        // reset in the middle of a nested handshake
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_we = 1'b1; cfg_wdata = 16'hFFFF;
        tick();
        quiet();
        src_req = 16'h0008;
        tick();
        src_req = 16'h0000;
        tick();
        chk("mid_ask3", {31'd0, ifc0.int_ask}, 32'd1);
        chk("mid_num3", {24'd0, ifc0.int_num}, 32'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        src_req = 16'h1002;
        tick();
        src_req = 16'h0000;
        tick();
        chk("mid_ask1", {31'd0, ifc0.int_ask}, 32'd1);
        chk("mid_num1", {24'd0, ifc0.int_num}, 32'd1);
        chk("mid_pend", {16'd0, pend0}, 32'h1002);
        chk("mid_isr", {16'd0, isr0}, 32'h0008);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_ask", {31'd0, ifc0.int_ask}, 32'd0);
        chk("rst2_ask_wrap", {31'd0, ifc1.int_ask}, 32'd0);
        chk("rst2_num", {24'd0, ifc0.int_num}, 32'd0);
        chk("rst2_pend", {16'd0, pend0}, 32'd0);
        chk("rst2_isr", {16'd0, isr0}, 32'd0);
        chk("rst2_en", {16'd0, en0}, 32'd0);
        tick();
        chk_model("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
